// File: rtl/eth_parser_pkg.sv
//------------------------------------------------------------------------------
// Module      : eth_parser_pkg
// Description : Ethernet parser types, the metadata queue entry and capture
//               FSM state encodings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package eth_parser_pkg;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    typedef struct packed {
        mac_addr_t   dest_mac;
        mac_addr_t   src_mac;
        logic        vlan_present;
        logic [11:0] vlan_id;
        ethertype_t  ethertype;
        logic [4:0]  l2_header_len;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_unknown;
    } eth_metadata_t;

    localparam int c_SEQ_W_DEFAULT = 8;

    // Queue entry layout; the queue packs the same fields at its own SEQ_W.
    typedef struct packed {
        eth_metadata_t                metadata;
        logic [c_SEQ_W_DEFAULT-1:0]   seq;
        logic                         truncated;
    } meta_entry_t;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_EMITTED = 2'd2;

endpackage

`default_nettype wire

// File: rtl/meta_fifo.sv
//------------------------------------------------------------------------------
// Module      : meta_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module meta_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               w_do_pop;

    // The caller only pushes when there is room or a pop happens in the same cycle.
    assign w_do_pop = i_pop && (r_level != '0);

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (i_push && !w_do_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (!i_push && w_do_pop) begin
                r_level <= r_level - c_LVL_W'(1);
            end
        end
    end

    assign o_pop_data = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_level    = r_level;

endmodule

`default_nettype wire

// File: rtl/metadata_queue.sv
//------------------------------------------------------------------------------
// Module      : metadata_queue
// Description : Captures one parsed-metadata entry per frame, tags it with a
//               sequence number and queues it; counts entries lost to overflow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module metadata_queue
    import eth_parser_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SEQ_W       = 8,
    parameter int CNT_W       = 16,
    parameter int EMIT_ON_END = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         frame_end,
    input  mac_addr_t                    dest_mac,
    input  mac_addr_t                    src_mac,
    input  logic                         vlan_present,
    input  logic [11:0]                  vlan_id,
    input  ethertype_t                   resolved_ethertype,
    input  logic [4:0]                   l2_header_len,
    input  logic                         proto_valid,
    input  logic                         is_ipv4,
    input  logic                         is_ipv6,
    input  logic                         is_arp,
    input  logic                         is_unknown,
    output logic                         m_valid,
    input  logic                         m_ready,
    output eth_metadata_t                m_metadata,
    output logic [SEQ_W-1:0]             m_seq,
    output logic                         m_truncated,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         overflow
);

    localparam int c_LVL_W   = $clog2(DEPTH+1);
    localparam int c_ENTRY_W = $bits(eth_metadata_t) + SEQ_W + 1;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [SEQ_W-1:0]     r_seq;
    logic [CNT_W-1:0]     r_drop_count;
    logic                 w_armed;
    logic                 w_normal_push;
    logic                 w_end_push;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_overflow;
    eth_metadata_t        w_meta_in;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_pop_data;
    logic [c_LVL_W-1:0]   w_level;

    assign w_armed       = (r_state == c_ST_ARMED);
    assign w_normal_push = w_armed && proto_valid;
    assign w_end_push    = (EMIT_ON_END != 0) && w_armed && frame_end && !proto_valid;
    assign w_push_req    = w_normal_push || w_end_push;

    assign w_pop      = m_valid && m_ready;
    assign w_accept   = w_push_req && ((w_level < c_LVL_W'(DEPTH)) || w_pop);
    assign w_overflow = w_push_req && !w_accept && !rst;

    // Frames closed without classification are reported as unknown protocol.
    always_comb begin
        w_meta_in               = '0;
        w_meta_in.dest_mac      = dest_mac;
        w_meta_in.src_mac       = src_mac;
        w_meta_in.vlan_present  = vlan_present;
        w_meta_in.vlan_id       = vlan_id;
        w_meta_in.ethertype     = resolved_ethertype;
        w_meta_in.l2_header_len = l2_header_len;
        w_meta_in.is_ipv4       = w_normal_push && is_ipv4;
        w_meta_in.is_ipv6       = w_normal_push && is_ipv6;
        w_meta_in.is_arp        = w_normal_push && is_arp;
        w_meta_in.is_unknown    = w_normal_push ? is_unknown : 1'b1;
    end

    assign w_push_data = {w_meta_in, r_seq, !w_normal_push};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ARMED: begin
                if (frame_end) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (proto_valid) begin
                    w_state_nxt = c_ST_EMITTED;
                end
            end
            c_ST_EMITTED: begin
                if (frame_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        // A new frame always re-arms, after the ending frame has been handled.
        if (frame_start) begin
            w_state_nxt = c_ST_ARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_seq        <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push_req) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_overflow && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    meta_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_level     (w_level)
    );

    assign {m_metadata, m_seq, m_truncated} = w_pop_data;
    assign m_valid    = (w_level != '0);
    assign fifo_level = w_level;
    assign drop_count = r_drop_count;
    assign overflow   = w_overflow;

endmodule

`default_nettype wire

// File: tb/tb_metadata_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_metadata_queue
// Description : Scoreboard bench for two metadata_queue configurations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_metadata_queue;
    import eth_parser_pkg::*;

    typedef struct {
        eth_metadata_t meta;
        int            seq;
        bit            trunc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0, frame_end = 1'b0, proto_valid = 1'b0;
    mac_addr_t     dest_mac = '0, src_mac = '0;
    logic          vlan_present = 1'b0;
    logic [11:0]   vlan_id = '0;
    ethertype_t    ethertype = '0;
    logic [4:0]    l2_len = '0;
    logic          is_ipv4 = 1'b0, is_ipv6 = 1'b0, is_arp = 1'b0, is_unknown = 1'b0;
    logic          m_ready = 1'b0;

    logic          a_valid, a_trunc, a_ovf;
    eth_metadata_t a_meta;
    logic [7:0]    a_seq;
    logic [2:0]    a_level;
    logic [15:0]   a_drop;
    logic          b_valid, b_trunc, b_ovf;
    eth_metadata_t b_meta;
    logic [1:0]    b_seq;
    logic [2:0]    b_level;
    logic [1:0]    b_drop;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    exp_t sb [2][$];
    int   st [2]       = '{0, 0};
    int   seqn [2]     = '{0, 0};
    int   drops [2]    = '{0, 0};
    int   ovf_seen [2] = '{0, 0};

    always #5 clk = ~clk;

    metadata_queue #(.DEPTH(4), .SEQ_W(8), .CNT_W(16), .EMIT_ON_END(0)) dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .dest_mac(dest_mac), .src_mac(src_mac), .vlan_present(vlan_present),
        .vlan_id(vlan_id), .resolved_ethertype(ethertype), .l2_header_len(l2_len),
        .proto_valid(proto_valid), .is_ipv4(is_ipv4), .is_ipv6(is_ipv6),
        .is_arp(is_arp), .is_unknown(is_unknown), .m_valid(a_valid), .m_ready(m_ready),
        .m_metadata(a_meta), .m_seq(a_seq), .m_truncated(a_trunc),
        .fifo_level(a_level), .drop_count(a_drop), .overflow(a_ovf));

    metadata_queue #(.DEPTH(4), .SEQ_W(2), .CNT_W(2), .EMIT_ON_END(1)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .dest_mac(dest_mac), .src_mac(src_mac), .vlan_present(vlan_present),
        .vlan_id(vlan_id), .resolved_ethertype(ethertype), .l2_header_len(l2_len),
        .proto_valid(proto_valid), .is_ipv4(is_ipv4), .is_ipv6(is_ipv6),
        .is_arp(is_arp), .is_unknown(is_unknown), .m_valid(b_valid), .m_ready(m_ready),
        .m_metadata(b_meta), .m_seq(b_seq), .m_truncated(b_trunc),
        .fifo_level(b_level), .drop_count(b_drop), .overflow(b_ovf));

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic eth_metadata_t cur_meta(input bit trunc);
        eth_metadata_t m;
        m = '0;
        m.dest_mac      = dest_mac;
        m.src_mac       = src_mac;
        m.vlan_present  = vlan_present;
        m.vlan_id       = vlan_id;
        m.ethertype     = ethertype;
        m.l2_header_len = l2_len;
        if (trunc) begin
            m.is_unknown = 1'b1;
        end else begin
            {m.is_ipv4, m.is_ipv6, m.is_arp, m.is_unknown} = {is_ipv4, is_ipv6, is_arp, is_unknown};
        end
        return m;
    endfunction

    // Checks the outputs of one instance, then advances its reference model by one edge.
    task automatic model_step(input int i);
        logic v, tr, ov;
        eth_metadata_t md;
        int sq, lvl, dc;
        bit exp_v, pop, pn, pe, preq, acc;
        exp_t e;
        string p;
        if (i == 0) begin
            p = "a"; v = a_valid; md = a_meta; sq = int'(a_seq); tr = a_trunc;
            lvl = int'(a_level); dc = int'(a_drop); ov = a_ovf;
        end else begin
            p = "b"; v = b_valid; md = b_meta; sq = int'(b_seq); tr = b_trunc;
            lvl = int'(b_level); dc = int'(b_drop); ov = b_ovf;
        end
        exp_v = (sb[i].size() != 0);
        chk({p, ".m_valid"}, 160'(v), 160'(exp_v));
        chk({p, ".fifo_level"}, 160'(lvl), 160'(sb[i].size()));
        chk({p, ".drop_count"}, 160'(dc), 160'(drops[i]));
        if (exp_v) begin
            chk({p, ".m_metadata"}, 160'(md), 160'(sb[i][0].meta));
            chk({p, ".m_seq"}, 160'(sq), 160'(sb[i][0].seq));
            chk({p, ".m_truncated"}, 160'(tr), 160'(sb[i][0].trunc));
        end else begin
            chk({p, ".idle_payload"}, 160'({md, tr}), 160'(0));
            chk({p, ".idle_seq"}, 160'(sq), 160'(0));
        end
        if (ov) ovf_seen[i]++;
        if (rst) begin
            chk({p, ".overflow_in_rst"}, 160'(ov), 160'(0));
            sb[i].delete();
            st[i] = 0; seqn[i] = 0; drops[i] = 0;
            return;
        end
        pop  = exp_v && m_ready;
        pn   = (st[i] == 1) && proto_valid;
        pe   = (i == 1) && (st[i] == 1) && frame_end && !proto_valid;
        preq = pn || pe;
        acc  = preq && ((sb[i].size() < 4) || pop);
        chk({p, ".overflow"}, 160'(ov), 160'(preq && !acc));
        if (pop) void'(sb[i].pop_front());
        if (acc) begin
            e.meta = cur_meta(pe); e.seq = seqn[i]; e.trunc = pe;
            sb[i].push_back(e);
        end
        if (preq) seqn[i] = (seqn[i] + 1) % ((i == 0) ? 256 : 4);
        if (preq && !acc && drops[i] < ((i == 0) ? 65535 : 3)) drops[i]++;
        if (st[i] == 1) begin
            if (frame_end) st[i] = 0;
            else if (proto_valid) st[i] = 2;
        end else if (st[i] == 2 && frame_end) begin
            st[i] = 0;
        end
        if (frame_start) st[i] = 1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    task automatic cyc(input bit fs, input bit fe, input bit pv);
        int k;
        frame_start  = fs;
        frame_end    = fe;
        proto_valid  = pv;
        dest_mac     = 48'({$urandom(), $urandom()});
        src_mac      = 48'({$urandom(), $urandom()});
        vlan_present = 1'($urandom());
        vlan_id      = 12'($urandom());
        ethertype    = 16'($urandom());
        l2_len       = 5'($urandom());
        k = $urandom_range(0, 3);
        {is_ipv4, is_ipv6, is_arp, is_unknown} = 4'b1000 >> k;
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();
        chk("reset.drop_count", 160'(a_drop), 160'(0));

        // Single classified frame with IPv4 forced.
        m_ready = 1'b1;
        cyc(1, 0, 0);
        frame_start = 1'b0; proto_valid = 1'b1;
        {is_ipv4, is_ipv6, is_arp, is_unknown} = 4'b1000;
        @(posedge clk); #1;
        chk("ipv4.valid_after_push", 160'(a_valid), 160'(1));
        chk("ipv4.seq0", 160'(a_seq), 160'(0));
        chk("ipv4.is_ipv4", 160'(a_meta.is_ipv4), 160'(1));
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        // proto_valid held for five cycles yields one entry.
        cyc(1, 0, 0);
        for (int n = 0; n < 5; n++) cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        // Same-cycle corner cases.
        cyc(1, 0, 0); cyc(0, 1, 1); cyc(0, 0, 1);
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(0, 0, 1); cyc(0, 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);

        // Frame ending unclassified.
        do_reset();
        m_ready = 1'b0;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("eoe1.level", 160'(b_level), 160'(1));
        chk("eoe1.truncated", 160'(b_trunc), 160'(1));
        chk("eoe1.is_unknown", 160'(b_meta.is_unknown), 160'(1));
        chk("eoe0.level", 160'(a_level), 160'(0));
        m_ready = 1'b1;
        cyc(0, 0, 0); cyc(0, 0, 0);

        // Overflow with a stalled consumer.
        do_reset();
        m_ready = 1'b0;
        ovf_seen = '{0, 0};
        for (int n = 0; n < 6; n++) frame();
        chk("ovf.level", 160'(a_level), 160'(4));
        chk("ovf.drop_count", 160'(a_drop), 160'(2));
        chk("ovf.pulses", 160'(ovf_seen[0]), 160'(2));
        m_ready = 1'b1;
        chk("ovf.first_seq", 160'(a_seq), 160'(0));
        for (int n = 0; n < 6; n++) cyc(0, 0, 0);

        // Narrow sequence and counter wrap/saturation.
        do_reset();
        for (int n = 0; n < 5; n++) frame();
        cyc(0, 0, 0); cyc(0, 0, 0);
        m_ready = 1'b0;
        for (int n = 0; n < 9; n++) frame();
        chk("sat.drop_b", 160'(b_drop), 160'(3));
        chk("sat.drop_a", 160'(a_drop), 160'(5));

        // Reset with entries queued and the FSM armed.
        do_reset();
        for (int n = 0; n < 3; n++) frame();
        cyc(1, 0, 0);
        chk("rst.level_before", 160'(a_level), 160'(3));
        do_reset();
        chk("rst.valid", 160'(a_valid), 160'(0));
        chk("rst.level", 160'(a_level), 160'(0));
        cyc(0, 0, 1); cyc(0, 0, 1);
        chk("rst.no_capture", 160'({a_level, b_level}), 160'(0));

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
